ioctl_mem_arbiter: RTL and testbench
====================================

IOCTL_MEM_ARBITER -- requirements
Module: ioctl_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the width of the memory address and the number of ioctl_addr bits used.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of download write-buffer entries (power of two, minimum 2).
REQ-003 SHALL have parameter CPU_BURST, default 8, meaning the maximum number of consecutive CPU grants while download data is waiting.
REQ-004 SHALL have ports, one per line:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  download byte strobe, one cycle wide.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- cpu_req  in  1  CPU access request, one-cycle pulse.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  CPU address; sampled with cpu_req.
- cpu_din  in  8  CPU write data; sampled with cpu_req.
- cpu_ack  out  1  access complete, one-cycle pulse.
- cpu_dout  out  8  read data; valid while cpu_ack=1 for a read.
- mem_ce  out  1  memory cycle strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  8  memory write data.
- mem_dout  in  8  synchronous RAM read data, valid the cycle after mem_ce.
- dl_overflow  out  1  sticky flag: a download byte was dropped.
- cpu_proto_err  out  1  sticky flag: cpu_req arrived while a CPU access was already pending.
- dl_done  out  1  one-cycle pulse: download finished and fully written.

Function
REQ-005 SHALL register all outputs.
REQ-006 SHALL share a single-port synchronous RAM between the CPU and the download path.
REQ-007 SHALL push {ioctl_addr[ADDR_W-1:0], ioctl_dout} into the FIFO on ioctl_wr & ioctl_download.
- Upper ioctl_addr bits SHALL be ignored.
- ioctl_wr with ioctl_download=0 SHALL be ignored.
REQ-008 SHALL handle a push to a full FIFO as follows: drop the byte, leave the FIFO unchanged, set dl_overflow.
- A simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-009 SHALL latch cpu_req into a single pending slot (we, addr, din).
- cpu_req while the slot is pending or in service SHALL be dropped and SHALL set cpu_proto_err.
REQ-010 SHALL implement FSM states IDLE, CPU_RD, CPU_RD_WAIT, CPU_WR, DL_WR.
REQ-011 SHALL make the IDLE grant decision each cycle as follows:
- CPU pending and (FIFO empty or burst_cnt < CPU_BURST) -> CPU_RD or CPU_WR.
- Else FIFO non-empty -> DL_WR.
- Else stay in IDLE.
- A cpu_req arriving in the same cycle SHALL be eligible for the grant decision in the following cycle.
REQ-012 SHALL keep burst_cnt as follows:
- Increment on each CPU grant while the FIFO is non-empty, saturating at CPU_BURST.
- Clear on each DL_WR grant, and when the FIFO is empty.
REQ-013 SHALL drive the CPU_WR state as: mem_ce=1, mem_we=1 for one cycle, cpu_ack next cycle, then IDLE.
REQ-014 SHALL drive the CPU_RD state as: mem_ce=1, mem_we=0 for one cycle, then CPU_RD_WAIT.
- In CPU_RD_WAIT, cpu_dout SHALL capture mem_dout and cpu_ack SHALL be asserted in the following cycle, then IDLE.
REQ-015 SHALL drive the DL_WR state as: mem_ce=1, mem_we=1, pop FIFO head for one cycle, then IDLE.
REQ-016 SHALL meet these latencies from cpu_req sampled at edge k, with the arbiter idle and no download priority:
- mem_ce high in cycle k+2.
- Write: cpu_ack in cycle k+3.
- Read: cpu_ack with data in cycle k+4.
REQ-017 SHALL hold mem_ce=0 and mem_we=0 outside CPU_RD/CPU_WR/DL_WR, with mem_addr and mem_din holding their last values.
REQ-018 SHALL pulse dl_done once, on the first cycle where all of the following hold after a 1->0 transition of ioctl_download:
- ioctl_download=0.
- FIFO empty.
- FSM not in DL_WR.
REQ-019 SHALL clear dl_overflow and cpu_proto_err only on reset, or on the rising edge of ioctl_download.

Reset
REQ-020 SHALL on reset assertion asynchronously force the following:
- FSM=IDLE, FIFO empty, pending slot cleared, burst_cnt=0.
- All outputs 0, including cpu_dout=0 and mem_addr=0.
REQ-021 SHALL abandon any in-flight access on reset mid-operation, with no cpu_ack or dl_done issued for it.

Verification
REQ-022 CPU read: preload RAM[0x1234]=0xA5; cpu_req, we=0, addr=0x1234 at edge k -> mem_ce in k+2; cpu_ack=1, cpu_dout=0xA5 in k+4.
REQ-023 Download: ioctl_download=1; 16 bytes to addresses 0x10000..0x1000F, one every 6 cycles -> RAM[0x0000..0x000F] correct; dl_overflow=0; single dl_done after ioctl_download falls.
REQ-024 Overflow and starvation:
- Bytes on consecutive cycles with CPU reads continuous -> FIFO fills; 5th byte dropped; dl_overflow=1.
- After 8 CPU grants, a DL_WR grant occurs.
REQ-025 Protocol error: second cpu_req before cpu_ack -> cpu_proto_err=1; exactly one cpu_ack returned.
REQ-026 Reset mid-download: reset while the FIFO holds 3 entries -> FIFO empty; no further mem_ce; outputs 0; no dl_done.

Source files
------------

// File: rtl/ioctl_mem_arbiter.sv
// ioctl_mem_arbiter: shares one synchronous single-port RAM between a CPU port and a FIFO-buffered ioctl download stream.
module ioctl_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CPU_BURST  = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              dl_overflow,
  output logic              cpu_proto_err,
  output logic              dl_done
);
  localparam logic [2:0] IDLE = 3'd0, CPU_RD = 3'd1, CPU_RD_WAIT = 3'd2, CPU_WR = 3'd3, DL_WR = 3'd4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CPU_BURST + 1);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W+7:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;
  logic [BW-1:0]     burst_q, burst_d;
  logic              pend_q, pwe_q, dl_q, armed_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [7:0]        pdin_q;
  logic [ADDR_W+7:0] head;
  logic empty, full, idle, cpu_gnt, dl_gnt, push, push_ok, fin, busy, rise, fall, done_c;
  logic unused;
  assign unused = ^ioctl_addr[24:ADDR_W];
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == (PW+1)'(FIFO_DEPTH);
    idle    = state_q == IDLE;
    cpu_gnt = idle & pend_q & (empty | (burst_q < BW'(CPU_BURST)));
    dl_gnt  = idle & ~cpu_gnt & ~empty;
    push    = ioctl_wr & ioctl_download;
    push_ok = push & (~full | dl_gnt);
    // the slot frees on the edge that issues cpu_ack, so back-to-back requests can chain
    fin     = (state_q == CPU_WR) | (state_q == CPU_RD_WAIT);
    busy    = pend_q & ~fin;
    rise    = ioctl_download & ~dl_q;
    fall    = dl_q & ~ioctl_download;
    done_c  = (armed_q | fall) & ~ioctl_download & empty & (state_q != DL_WR);
    head    = fifo_q[rp_q];
    state_d = cpu_gnt ? (pwe_q ? CPU_WR : CPU_RD) : dl_gnt ? DL_WR : (state_q == CPU_RD) ? CPU_RD_WAIT : IDLE;
    burst_d = (empty | dl_gnt) ? '0 : cpu_gnt ? burst_q + 1'b1 : burst_q;
  end
  always_ff @(posedge clk_sys)
    if (push_ok) fifo_q[wp_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      burst_q       <= '0;
      pend_q        <= 1'b0;
      pwe_q         <= 1'b0;
      paddr_q       <= '0;
      pdin_q        <= '0;
      dl_q          <= 1'b0;
      armed_q       <= 1'b0;
      cpu_ack       <= 1'b0;
      cpu_dout      <= '0;
      mem_ce        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      dl_overflow   <= 1'b0;
      cpu_proto_err <= 1'b0;
      dl_done       <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      wp_q          <= push_ok ? wp_q + 1'b1 : wp_q;
      rp_q          <= dl_gnt ? rp_q + 1'b1 : rp_q;
      cnt_q         <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(dl_gnt);
      pend_q        <= (cpu_req & ~busy) | (pend_q & ~fin);
      pwe_q         <= (cpu_req & ~busy) ? cpu_we : pwe_q;
      paddr_q       <= (cpu_req & ~busy) ? cpu_addr : paddr_q;
      pdin_q        <= (cpu_req & ~busy) ? cpu_din : pdin_q;
      dl_q          <= ioctl_download;
      armed_q       <= ~ioctl_download & ~done_c & (armed_q | fall);
      cpu_ack       <= fin;
      cpu_dout      <= (state_q == CPU_RD_WAIT) ? mem_dout : cpu_dout;
      mem_ce        <= cpu_gnt | dl_gnt;
      mem_we        <= dl_gnt | (cpu_gnt & pwe_q);
      mem_addr      <= cpu_gnt ? paddr_q : dl_gnt ? head[ADDR_W+7:8] : mem_addr;
      mem_din       <= cpu_gnt ? pdin_q : dl_gnt ? head[7:0] : mem_din;
      dl_overflow   <= (dl_overflow & ~rise) | (push & full & ~dl_gnt);
      cpu_proto_err <= (cpu_proto_err & ~rise) | (cpu_req & busy);
      dl_done       <= done_c;
    end
  end
endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// tb_ioctl_mem_arbiter: directed plus randomized checks of the arbiter against a behavioural RAM and shadow-memory model.
module tb_ioctl_mem_arbiter;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_ack, mem_ce, mem_we, dl_overflow, cpu_proto_err, dl_done;
  logic [7:0]  cpu_dout, mem_din, mem_dout;
  logic [15:0] mem_addr;
  logic [7:0]  ram [0:65535];
  int checks = 0, errors = 0, n_rd = 0, n_wr = 0, n_ack = 0, n_done = 0;

  ioctl_mem_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dl_overflow(dl_overflow), .cpu_proto_err(cpu_proto_err), .dl_done(dl_done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys)
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end

  always @(negedge clk_sys) begin
    if (mem_ce && !mem_we) n_rd++;
    if (mem_ce && mem_we) n_wr++;
    if (cpu_ack) n_ack++;
    if (dl_done) n_done++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {cpu_ack, cpu_dout, mem_ce, mem_we, mem_addr, mem_din, dl_overflow, cpu_proto_err, dl_done};
  endfunction

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  // lat counts cycles from the request edge: 1 is the cycle right after it, -1 means no ack
  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    int off;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    step();
    cpu_req = 1'b0;
    off = 1;
    while (!cpu_ack && off < 60) begin
      step();
      off++;
    end
    lat = cpu_ack ? off : -1;
    rd = cpu_dout;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] dl_data [16];
    logic [7:0] ovf_data [5];
    logic [7:0] sh [16];
    logic [7:0] rnd_data [24];
    int lat, b_rd, b_wr, b_ack, b_done, k;

    step(3);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    step(2);
    chk("idle_after_reset", outs(), 0);

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 8'hA5;
    step();
    cpu_req = 1'b0;
    chk("wr_k1_quiet", {mem_ce, cpu_ack}, 0);
    step();
    chk("wr_k2_mem", {mem_ce, mem_we, mem_addr, mem_din}, {1'b1, 1'b1, 16'h1234, 8'hA5});
    step();
    chk("wr_k3_ack", {cpu_ack, mem_ce}, 2'b10);
    step();
    chk("wr_ack_pulse", cpu_ack, 0);

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_din = 8'h00;
    step();
    cpu_req = 1'b0;
    step();
    chk("rd_k2_mem", {mem_ce, mem_we, mem_addr}, {1'b1, 1'b0, 16'h1234});
    step();
    chk("rd_k3_quiet", {mem_ce, cpu_ack}, 0);
    step();
    chk("rd_k4_ack_data", {cpu_ack, cpu_dout}, {1'b1, 8'hA5});
    step();
    chk("rd_ack_pulse", cpu_ack, 0);
    chk("mem_addr_hold", mem_addr, 16'h1234);

    b_ack = n_ack;
    cpu_req = 1'b1; cpu_we = 1'b0;
    step(2);
    cpu_req = 1'b0;
    step(10);
    chk("proto_err_set", cpu_proto_err, 1);
    chk("proto_one_ack", n_ack - b_ack, 1);

    b_done = n_done;
    ioctl_download = 1'b1;
    step();
    chk("rise_clears_proto", cpu_proto_err, 0);
    for (int i = 0; i < 16; i++) begin
      dl_data[i] = 8'($urandom);
      dl_byte(25'h10000 + 25'(i), dl_data[i]);
      step(5);
    end
    chk("dl_no_done_early", n_done - b_done, 0);
    ioctl_download = 1'b0;
    step(10);
    chk("dl_single_done", n_done - b_done, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("dl_ram_%0d", i), ram[i], dl_data[i]);
    chk("dl_no_overflow", dl_overflow, 0);
    b_wr = n_wr;
    dl_byte(25'h00020, 8'h5A);
    step(5);
    chk("wr_without_dl_ignored", n_wr - b_wr, 0);

    ioctl_download = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    step(6);
    b_wr = n_wr;
    b_rd = n_rd;
    for (int i = 0; i < 5; i++) begin
      ovf_data[i] = 8'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = 25'h40 + 25'(i); ioctl_dout = ovf_data[i];
      step();
      if (i == 0) b_rd = n_rd;
    end
    ioctl_wr = 1'b0;
    chk("ovf_flag", dl_overflow, 1);
    k = 0;
    while (n_wr == b_wr && k < 100) begin
      step();
      k++;
    end
    chk("starve_dl_granted", n_wr - b_wr, 1);
    chk("starve_cpu_grants", n_rd - b_rd, 8);
    chk("proto_err_continuous", cpu_proto_err, 1);
    cpu_req = 1'b0;
    k = 0;
    while (n_wr - b_wr < 4 && k < 200) begin
      step();
      k++;
    end
    step(20);
    chk("ovf_four_writes", n_wr - b_wr, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_ram_%0d", i), ram[16'h40 + 16'(i)], ovf_data[i]);
    chk("ovf_byte_dropped", ram[16'h44] === ovf_data[4], 0);
    ioctl_download = 1'b0;
    step(5);
    chk("ovf_sticky", dl_overflow, 1);
    ioctl_download = 1'b1;
    step();
    chk("flags_clear_on_rise", {dl_overflow, cpu_proto_err}, 0);
    ioctl_download = 1'b0;
    step(5);

    ioctl_download = 1'b1; cpu_req = 1'b1;
    step(6);
    b_wr = n_wr;
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'h60 + 25'(i); ioctl_dout = 8'($urandom);
      step();
    end
    ioctl_wr = 1'b0;
    step(2);
    chk("rst_fifo_held", n_wr - b_wr, 0);
    #2 reset = 1'b1;
    #1 chk("rst_async_outputs", outs(), 0);
    cpu_req = 1'b0; ioctl_download = 1'b0;
    step(3);
    reset = 1'b0;
    b_wr = n_rd + n_wr; b_done = n_done; b_ack = n_ack;
    step(20);
    chk("rst_no_mem_ce", n_rd + n_wr - b_wr, 0);
    chk("rst_no_done", n_done - b_done, 0);
    chk("rst_no_ack", n_ack - b_ack, 0);
    chk("rst_outputs_idle", outs(), 0);

    for (int i = 0; i < 16; i++) begin
      sh[i] = 8'($urandom);
      cpu_op(1'b1, 16'h8000 + 16'(i), sh[i], rd, lat);
      chk("init_wr_latency", lat, 3);
    end
    b_done = n_done;
    ioctl_download = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          rnd_data[i] = 8'($urandom);
          step($urandom_range(7, 11));
          dl_byte({9'($urandom), 16'h0100 + 16'(i)}, rnd_data[i]);
        end
      end
      begin
        logic [7:0] crd, cd;
        logic       cwe;
        int         clat, idx;
        for (int j = 0; j < 40; j++) begin
          cwe = 1'($urandom);
          idx = $urandom_range(0, 15);
          cd  = 8'($urandom);
          step($urandom_range(0, 3));
          cpu_op(cwe, 16'h8000 + 16'(idx), cd, crd, clat);
          chk("rnd_ack", clat > 0, 1);
          if (cwe) sh[idx] = cd;
          else chk($sformatf("rnd_rd_%0d", j), crd, sh[idx]);
        end
      end
    join
    step(5);
    ioctl_download = 1'b0;
    k = 0;
    while (n_done == b_done && k < 50) begin
      step();
      k++;
    end
    step(5);
    chk("rnd_single_done", n_done - b_done, 1);
    for (int i = 0; i < 24; i++) chk($sformatf("rnd_dl_ram_%0d", i), ram[16'h0100 + 16'(i)], rnd_data[i]);
    chk("rnd_no_overflow", dl_overflow, 0);
    chk("rnd_no_proto_err", cpu_proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
